multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 67 ++++++
 rtl/multicycle_control_alu_dec.sv | 46 ++++
 rtl/multicycle_control.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM state
// encoding, ALU control codes, immediate-format selects, opcodes and the
// ALU-op selector passed to the ALU decoder.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd14
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation class handed from the FSM to the ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:         imm_sel = IMM_S;
            OP_BRANCH:        imm_sel = IMM_B;
            OP_JAL:           imm_sel = IMM_J;
            OP_LUI, OP_AUIPC: imm_sel = IMM_U;
            default:          imm_sel = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_dec.sv
// alu_decoder_ext: combinational ALU control decode.
// Ports:
//   op_b5_i       - opcode bit 5 (1 = R-type, 0 = I-type for ALU ops)
//   funct3_i      - instruction funct3
//   funct7_b5_i   - instruction bit 30
//   alu_op_i      - operation class from the FSM (ADD / SUB / FUNCT)
//   alu_control_o - ALU control code, zero-padded to ALU_CTRL_W
module alu_decoder_ext
    import multicycle_control_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  op_b5_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7_b5_i,
    input  logic [1:0]            alu_op_i,
    output logic [ALU_CTRL_W-1:0] alu_control_o
);

    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // addi has no subtract form: bit 30 is immediate data there
                    3'b000:  code = (op_b5_i && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    // bit 30 picks arithmetic shift for both srai and sra
                    3'b101:  code = funct7_b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM. Moore outputs per state, except pc_write in
// BRANCH (flag dependent) and the mem_ready gating of FETCH/MEMREAD/MEMWRITE.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   op, funct3, funct7_b5 - instruction fields from the instruction register
//   zero, lt, ltu        - ALU flags for branch resolution
//   mem_ready            - memory completes the current access
//   pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal
//   alu_src_a, alu_src_b, result_src, imm_src, alu_control - datapath controls
//   state                - current FSM state (debug)
// ALU_CTRL_W must be at least 4.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_HS     = 1,
    parameter int EXT_BRANCH = 1,
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_b5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  illegal,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state
);

    state_e     state_q, state_d;
    logic       mem_rdy;
    logic       taken;
    logic       br_illegal;
    logic [1:0] alu_op;
    logic       pc_write_c, ir_write_c, reg_write_c;
    logic       mem_req_c, mem_write_c, illegal_c;

    assign mem_rdy = (MEM_HS != 0) ? mem_ready : 1'b1;

    // 010/011 are never branches; 1xx exist only with the extended set.
    assign br_illegal = (funct3[2:1] == 2'b01) || (funct3[2] && (EXT_BRANCH == 0));

    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        illegal_c   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_op      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_rdy) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = br_illegal ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                // ALUOut still holds the target computed in DECODE
                alu_src_a  = 2'b10;
                alu_op     = ALUOP_SUB;
                pc_write_c = taken;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                pc_write_c  = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JALR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                result_src  = 2'b10;
                pc_write_c  = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_LUI: begin
                alu_src_a   = 2'b11;    // constant zero operand
                alu_src_b   = 2'b01;
                result_src  = 2'b10;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_AUIPC: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                result_src  = 2'b10;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase
    end

    // rst_n masks the strobes so FETCH's defaults never leak out while
    // reset is held, and a reset mid-access drops them immediately.
    assign pc_write  = pc_write_c  & rst_n;
    assign ir_write  = ir_write_c  & rst_n;
    assign reg_write = reg_write_c & rst_n;
    assign mem_req   = mem_req_c   & rst_n;
    assign mem_write = mem_write_c & rst_n;
    assign illegal   = illegal_c   & rst_n;
    assign imm_src   = imm_sel(op);
    assign state     = state_q;

    alu_decoder_ext #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_dec (
        .op_b5_i      (op[5]),
        .funct3_i     (funct3),
        .funct7_b5_i  (funct7_b5),
        .alu_op_i     (alu_op),
        .alu_control_o(alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a vector table covering decode,
// ALU control and branch resolution, plus hand sequences for reset, stalls,
// trap absorption and reset during a store.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_b5, zero, lt, ltu, mem_ready;

    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control, state;

    logic       nb_pc_write, nb_adr_src, nb_mem_req, nb_mem_write, nb_ir_write, nb_reg_write, nb_illegal;
    logic [1:0] nb_alu_src_a, nb_alu_src_b, nb_result_src;
    logic [2:0] nb_imm_src;
    logic [3:0] nb_alu_control, nb_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_b5(funct7_b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .illegal(illegal),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .imm_src(imm_src), .alu_control(alu_control), .state(state)
    );

    multicycle_control #(.EXT_BRANCH(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_b5(funct7_b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(nb_pc_write), .adr_src(nb_adr_src), .mem_req(nb_mem_req), .mem_write(nb_mem_write),
        .ir_write(nb_ir_write), .reg_write(nb_reg_write), .illegal(nb_illegal),
        .alu_src_a(nb_alu_src_a), .alu_src_b(nb_alu_src_b), .result_src(nb_result_src),
        .imm_src(nb_imm_src), .alu_control(nb_alu_control), .state(nb_state)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7, z, l, lu;
        logic [3:0] st, st_nb, alu;
        logic [2:0] imm;
        logic       pcw, rw, ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_v(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic l, input logic lu,
                         input logic [3:0] st, input logic [3:0] st_nb, input logic [3:0] alu,
                         input logic [2:0] imm, input logic pcw, input logic rw, input logic ill);
        vec_t v;
        v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.l = l; v.lu = lu;
        v.st = st; v.st_nb = st_nb; v.alu = alu; v.imm = imm;
        v.pcw = pcw; v.rw = rw; v.ill = ill;
        vecs.push_back(v);
    endtask

    // Pulse reset mid-cycle; the DUT sits in FETCH until the next rising edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    // Advance to the middle of the next cycle.
    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // op f3 f7 z lt ltu | state state_nb alu imm pcw rw ill
        add_v(7'b0110011, 3'b000, 0, 0, 0, 0, 4'd6,  4'd6,  4'd0, 3'b000, 0, 0, 0); // add
        add_v(7'b0110011, 3'b000, 1, 0, 0, 0, 4'd6,  4'd6,  4'd1, 3'b000, 0, 0, 0); // sub
        add_v(7'b0110011, 3'b111, 0, 0, 0, 0, 4'd6,  4'd6,  4'd2, 3'b000, 0, 0, 0); // and
        add_v(7'b0110011, 3'b110, 0, 0, 0, 0, 4'd6,  4'd6,  4'd3, 3'b000, 0, 0, 0); // or
        add_v(7'b0110011, 3'b100, 0, 0, 0, 0, 4'd6,  4'd6,  4'd4, 3'b000, 0, 0, 0); // xor
        add_v(7'b0110011, 3'b010, 0, 0, 0, 0, 4'd6,  4'd6,  4'd5, 3'b000, 0, 0, 0); // slt
        add_v(7'b0110011, 3'b011, 0, 0, 0, 0, 4'd6,  4'd6,  4'd6, 3'b000, 0, 0, 0); // sltu
        add_v(7'b0110011, 3'b001, 0, 0, 0, 0, 4'd6,  4'd6,  4'd7, 3'b000, 0, 0, 0); // sll
        add_v(7'b0110011, 3'b101, 0, 0, 0, 0, 4'd6,  4'd6,  4'd8, 3'b000, 0, 0, 0); // srl
        add_v(7'b0110011, 3'b101, 1, 0, 0, 0, 4'd6,  4'd6,  4'd9, 3'b000, 0, 0, 0); // sra
        add_v(7'b0010011, 3'b000, 1, 0, 0, 0, 4'd7,  4'd7,  4'd0, 3'b000, 0, 0, 0); // addi, bit30 set
        add_v(7'b0010011, 3'b101, 1, 0, 0, 0, 4'd7,  4'd7,  4'd9, 3'b000, 0, 0, 0); // srai
        add_v(7'b0010011, 3'b101, 0, 0, 0, 0, 4'd7,  4'd7,  4'd8, 3'b000, 0, 0, 0); // srli
        add_v(7'b0010011, 3'b001, 0, 0, 0, 0, 4'd7,  4'd7,  4'd7, 3'b000, 0, 0, 0); // slli
        add_v(7'b0010011, 3'b010, 0, 0, 0, 0, 4'd7,  4'd7,  4'd5, 3'b000, 0, 0, 0); // slti
        add_v(7'b1100011, 3'b000, 0, 1, 0, 0, 4'd9,  4'd9,  4'd1, 3'b010, 1, 0, 0); // beq taken
        add_v(7'b1100011, 3'b000, 0, 0, 1, 1, 4'd9,  4'd9,  4'd1, 3'b010, 0, 0, 0); // beq not
        add_v(7'b1100011, 3'b001, 0, 0, 0, 0, 4'd9,  4'd9,  4'd1, 3'b010, 1, 0, 0); // bne taken
        add_v(7'b1100011, 3'b001, 0, 1, 1, 1, 4'd9,  4'd9,  4'd1, 3'b010, 0, 0, 0); // bne not
        add_v(7'b1100011, 3'b100, 0, 0, 1, 0, 4'd9,  4'd14, 4'd1, 3'b010, 1, 0, 0); // blt taken
        add_v(7'b1100011, 3'b100, 0, 1, 0, 1, 4'd9,  4'd14, 4'd1, 3'b010, 0, 0, 0); // blt not
        add_v(7'b1100011, 3'b101, 0, 0, 0, 1, 4'd9,  4'd14, 4'd1, 3'b010, 1, 0, 0); // bge taken
        add_v(7'b1100011, 3'b101, 0, 0, 1, 0, 4'd9,  4'd14, 4'd1, 3'b010, 0, 0, 0); // bge not
        add_v(7'b1100011, 3'b110, 0, 0, 0, 1, 4'd9,  4'd14, 4'd1, 3'b010, 1, 0, 0); // bltu taken
        add_v(7'b1100011, 3'b110, 0, 0, 1, 0, 4'd9,  4'd14, 4'd1, 3'b010, 0, 0, 0); // bltu not
        add_v(7'b1100011, 3'b111, 0, 0, 1, 0, 4'd9,  4'd14, 4'd1, 3'b010, 1, 0, 0); // bgeu taken
        add_v(7'b1100011, 3'b111, 0, 1, 0, 1, 4'd9,  4'd14, 4'd1, 3'b010, 0, 0, 0); // bgeu not
        add_v(7'b1100011, 3'b010, 0, 1, 1, 1, 4'd14, 4'd14, 4'd0, 3'b010, 0, 0, 1); // bad branch
        add_v(7'b1100011, 3'b011, 0, 1, 1, 1, 4'd14, 4'd14, 4'd0, 3'b010, 0, 0, 1); // bad branch
        add_v(7'b0000000, 3'b000, 0, 0, 0, 0, 4'd14, 4'd14, 4'd0, 3'b000, 0, 0, 1); // zero opcode
        add_v(7'b1111111, 3'b000, 0, 0, 0, 0, 4'd14, 4'd14, 4'd0, 3'b000, 0, 0, 1); // unknown op
        add_v(7'b0110111, 3'b000, 0, 0, 0, 0, 4'd12, 4'd12, 4'd0, 3'b100, 0, 1, 0); // lui
        add_v(7'b0010111, 3'b000, 0, 0, 0, 0, 4'd13, 4'd13, 4'd0, 3'b100, 0, 1, 0); // auipc
        add_v(7'b1101111, 3'b000, 0, 0, 0, 0, 4'd10, 4'd10, 4'd0, 3'b011, 1, 1, 0); // jal
        add_v(7'b1100111, 3'b000, 0, 0, 0, 0, 4'd11, 4'd11, 4'd0, 3'b000, 1, 1, 0); // jalr
        add_v(7'b0000011, 3'b010, 0, 0, 0, 0, 4'd2,  4'd2,  4'd0, 3'b000, 0, 0, 0); // lw
        add_v(7'b0100011, 3'b010, 0, 0, 0, 0, 4'd2,  4'd2,  4'd0, 3'b001, 0, 0, 0); // sw

        // ---- reset held: FETCH, every strobe low even with mem_ready high
        rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7_b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wr_en", 32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        next_cyc();
        chk("rst_held_state", 32'(state), 32'd0);

        // ---- add x3,x1,x2: FETCH, DECODE, EXEC_R, ALUWB, then FETCH
        rst_n = 1'b1;
        #1;
        chk("add_c1_state", 32'(state), 32'd0);
        chk("add_c1_fetch", 32'({mem_req, adr_src, ir_write, pc_write, alu_src_a, alu_src_b, result_src}),
            32'b1_0_1_1_00_10_10);
        chk("add_c1_rw", 32'(reg_write), 32'd0);
        next_cyc();
        chk("add_c2_state", 32'(state), 32'd1);
        chk("add_c2_src", 32'({alu_src_a, alu_src_b, reg_write}), 32'b01_01_0);
        next_cyc();
        chk("add_c3_state", 32'(state), 32'd6);
        chk("add_c3_alu_rw", 32'({alu_control, reg_write}), 32'b0000_0);
        next_cyc();
        chk("add_c4_state", 32'(state), 32'd8);
        chk("add_c4_rw", 32'({reg_write, result_src}), 32'b1_00);
        next_cyc();
        chk("add_c5_state", 32'(state), 32'd0);

        // ---- fetch stall: no ir/pc write and no progress without mem_ready
        mem_ready = 1'b0;
        #1;
        chk("fstall_strobes", 32'({mem_req, ir_write, pc_write}), 32'b100);
        next_cyc();
        chk("fstall_state", 32'(state), 32'd0);

        // ---- table sweep: third cycle after reset is the decoded state
        foreach (vecs[i]) begin
            @(negedge clk);
            op = vecs[i].op; funct3 = vecs[i].f3; funct7_b5 = vecs[i].f7;
            zero = vecs[i].z; lt = vecs[i].l; ltu = vecs[i].lu; mem_ready = 1'b1;
            pulse_reset();
            next_cyc();
            chk($sformatf("v%0d_decode", i), 32'(state), 32'd1);
            next_cyc();
            chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("v%0d_state_nb", i), 32'(nb_state), 32'(vecs[i].st_nb));
            chk($sformatf("v%0d_alu", i), 32'(alu_control), 32'(vecs[i].alu));
            chk($sformatf("v%0d_imm", i), 32'(imm_src), 32'(vecs[i].imm));
            chk($sformatf("v%0d_pcw", i), 32'(pc_write), 32'(vecs[i].pcw));
            chk($sformatf("v%0d_rw", i), 32'(reg_write), 32'(vecs[i].rw));
            chk($sformatf("v%0d_ill", i), 32'(illegal), 32'(vecs[i].ill));
        end

        // ---- lw with three stalled MEMREAD cycles: 8 cycles total
        @(negedge clk);
        op = 7'b0000011; funct3 = 3'b010; funct7_b5 = 1'b0; mem_ready = 1'b1;
        pulse_reset();
        next_cyc();                                   // DECODE
        next_cyc();                                   // MEMADR
        chk("lw_memadr", 32'({state, alu_src_a, alu_src_b}), 32'b0010_10_01);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lw_stall%0d", c), 32'({state, mem_req, adr_src, reg_write}), 32'b0011_1_1_0);
            next_cyc();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_ready", 32'({state, mem_req}), 32'b0011_1);
        next_cyc();
        chk("lw_memwb", 32'({state, reg_write, result_src}), 32'b0100_1_01);
        next_cyc();
        chk("lw_done", 32'(state), 32'd0);

        // ---- illegal opcode: TRAP absorbs with no writes for 10 cycles
        @(negedge clk);
        op = 7'b0000000; funct3 = 3'b000;
        pulse_reset();
        next_cyc();
        next_cyc();
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("trap%0d", c),
                32'({state, illegal, pc_write, ir_write, reg_write, mem_write, mem_req}),
                32'b1110_1_00000);
            next_cyc();
        end

        // ---- reset pulse during MEMWRITE aborts the store
        op = 7'b0100011; funct3 = 3'b010;
        pulse_reset();
        next_cyc();                                   // DECODE
        next_cyc();                                   // MEMADR
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("sw_memwrite", 32'({state, mem_req, mem_write, adr_src}), 32'b0101_1_1_1);
        rst_n = 1'b0;
        #1;
        chk("sw_rst_async", 32'({state, mem_req, mem_write}), 32'b0000_0_0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("sw_refetch", 32'({state, mem_req, ir_write}), 32'b0000_1_1);
        next_cyc();
        chk("sw_redecode", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
